// File: rtl/l2_cache_wb.sv
// Set-associative write-back, write-allocate L2 cache with multi-word lines,
// burst refill, victim write-back, per-set round-robin replacement and statistics.
module l2_cache_wb #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SETS       = 8,
    parameter int NUM_WAYS       = 4,
    parameter int WORDS_PER_LINE = 4,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_hit,
    output logic                  mem_valid,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count,
    output logic [CNT_WIDTH-1:0]  wb_count
);

    localparam int OFF_W  = $clog2(DATA_WIDTH / 8);
    localparam int WORD_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam int TAG_W  = ADDR_WIDTH - OFF_W - WORD_W - IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL,
        RESPOND
    } state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS][WORDS_PER_LINE];
    logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];
    logic [WAY_W-1:0]      rr_q    [NUM_SETS];

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [WAY_W-1:0]      way_q;
    logic [WORD_W-1:0]     beat_q;

    logic                  req_ready_q;
    logic                  resp_valid_q;
    logic                  resp_hit_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic [CNT_WIDTH-1:0]  hit_cnt_q, miss_cnt_q, wb_cnt_q;

    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      req_idx;
    logic [WORD_W-1:0]     req_word;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic                  inv_found;
    logic [WAY_W-1:0]      inv_way;
    logic [WAY_W-1:0]      victim_way;
    logic                  victim_dirty;
    logic                  beat_done;
    logic                  last_beat;
    logic [DATA_WIDTH-1:0] refill_word;
    logic [TAG_W-1:0]      mem_tag;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic                  unused_ok;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + CNT_WIDTH'(1);
    endfunction

    assign req_word = addr_q[OFF_W +: WORD_W];
    assign req_idx  = addr_q[OFF_W + WORD_W +: IDX_W];
    assign req_tag  = addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign unused_ok = ^addr_q;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        // Descending scan leaves the lowest-index invalid way selected.
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign victim_way   = inv_found ? inv_way : rr_q[req_idx];
    assign victim_dirty = valid_q[req_idx][victim_way] & dirty_q[req_idx][victim_way];

    assign mem_valid = (state_q == WRITEBACK) || (state_q == REFILL);
    assign mem_write = (state_q == WRITEBACK);
    assign beat_done = mem_valid && mem_ready;
    assign last_beat = (beat_q == {WORD_W{1'b1}});

    always_comb begin
        mem_tag   = (state_q == WRITEBACK) ? tag_q[req_idx][way_q] : req_tag;
        beat_addr = ADDR_WIDTH'({mem_tag, req_idx, beat_q}) << OFF_W;
    end

    assign mem_addr  = mem_valid ? beat_addr : '0;
    assign mem_wdata = (state_q == WRITEBACK) ? data_q[req_idx][way_q][beat_q] : '0;

    // The requested word may arrive on the completing beat itself.
    always_comb begin
        if (write_q) begin
            refill_word = wdata_q;
        end else if (req_word == beat_q) begin
            refill_word = mem_rdata;
        end else begin
            refill_word = data_q[req_idx][way_q][req_word];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (req_valid && req_ready_q) state_d = LOOKUP;
            LOOKUP: begin
                if (hit) begin
                    state_d = IDLE;
                end else if (victim_dirty) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = REFILL;
                end
            end
            WRITEBACK: if (beat_done && last_beat) state_d = REFILL;
            REFILL:    if (beat_done && last_beat) state_d = RESPOND;
            RESPOND:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_rdata_q <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            wb_cnt_q     <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            way_q        <= '0;
            beat_q       <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            req_ready_q  <= (state_d == IDLE);
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        addr_q  <= req_addr;
                        write_q <= req_write;
                        wdata_q <= req_wdata;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= 1'b1;
                        resp_rdata_q <= write_q ? wdata_q : data_q[req_idx][hit_way][req_word];
                        hit_cnt_q    <= sat_inc(hit_cnt_q);
                        if (write_q) dirty_q[req_idx][hit_way] <= 1'b1;
                    end else begin
                        miss_cnt_q <= sat_inc(miss_cnt_q);
                        way_q      <= victim_way;
                        beat_q     <= '0;
                        // Line stays invalid until its refill completes.
                        valid_q[req_idx][victim_way] <= 1'b0;
                        if (!inv_found) rr_q[req_idx] <= rr_q[req_idx] + WAY_W'(1);
                    end
                end
                WRITEBACK: begin
                    if (beat_done) begin
                        beat_q <= beat_q + WORD_W'(1);
                        if (last_beat) wb_cnt_q <= sat_inc(wb_cnt_q);
                    end
                end
                REFILL: begin
                    if (beat_done) begin
                        beat_q <= beat_q + WORD_W'(1);
                        if (last_beat) begin
                            valid_q[req_idx][way_q] <= 1'b1;
                            dirty_q[req_idx][way_q] <= write_q;
                            resp_valid_q            <= 1'b1;
                            resp_rdata_q            <= refill_word;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == LOOKUP) && hit && write_q) begin
            data_q[req_idx][hit_way][req_word] <= wdata_q;
        end
        if ((state_q == REFILL) && beat_done) begin
            data_q[req_idx][way_q][beat_q] <= mem_rdata;
            if (last_beat) begin
                tag_q[req_idx][way_q] <= req_tag;
                if (write_q) data_q[req_idx][way_q][req_word] <= wdata_q;
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign resp_rdata = resp_rdata_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
    assign wb_count   = wb_cnt_q;

endmodule

// File: tb/tb_l2_cache_wb.sv
// Scoreboard bench for l2_cache_wb: an array-based cache model predicts responses,
// memory beats and counters; monitors compare what the DUT actually presents.
module tb_l2_cache_wb;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NS  = 8;
    localparam int NW  = 4;
    localparam int WPL = 4;
    localparam int CW  = 4;
    localparam int LINE_BYTES = WPL * 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_hit;
    logic          mem_valid;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic [CW-1:0] hit_count, miss_count, wb_count;

    always #5 clk = ~clk;

    l2_cache_wb #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SETS(NS), .NUM_WAYS(NW),
        .WORDS_PER_LINE(WPL), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
        .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        logic          hit;
        int            acc;
    } resp_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } beat_t;

    resp_t exp_resp[$];
    beat_t exp_beat[$];

    int n_cmp = 0;
    int n_fail = 0;
    int pcyc = 0;
    int beats_done = 0;
    int ready_mode = 0;
    bit junk_en = 1'b0;

    // Reference cache: plain arrays indexed by set/way/word.
    bit            m_valid [NS][NW];
    bit            m_dirty [NS][NW];
    logic [AW-1:0] m_tag   [NS][NW];
    logic [DW-1:0] m_data  [NS][NW][WPL];
    int            m_rr    [NS];
    int            m_hits, m_miss, m_wbs;
    logic [DW-1:0] mem_ref [logic [AW-1:0]];
    logic [DW-1:0] mem_dut [logic [AW-1:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000 ^ a;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return mem_ref.exists(a) ? mem_ref[a] : init_word(a);
    endfunction

    function automatic logic [DW-1:0] dut_rd(input logic [AW-1:0] a);
        return mem_dut.exists(a) ? mem_dut[a] : init_word(a);
    endfunction

    function automatic logic [CW-1:0] sat(input int n);
        return (n >= (1 << CW) - 1) ? {CW{1'b1}} : CW'(n);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
        m_hits = 0;
        m_miss = 0;
        m_wbs  = 0;
    endtask

    task automatic model_access(input bit wr, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input int acc);
        int idx, word, way, vic;
        logic [AW-1:0] tag, a;
        idx  = int'((addr / LINE_BYTES) % NS);
        word = int'((addr / 4) % WPL);
        tag  = addr / (LINE_BYTES * NS);
        way  = -1;
        for (int w = 0; w < NW; w++)
            if (m_valid[idx][w] && m_tag[idx][w] == tag) way = w;
        if (way >= 0) begin
            m_hits++;
            if (wr) begin
                m_data[idx][way][word] = wdata;
                m_dirty[idx][way] = 1'b1;
            end
            exp_resp.push_back('{m_data[idx][way][word], 1'b1, acc});
        end else begin
            m_miss++;
            vic = -1;
            for (int w = 0; w < NW; w++)
                if (!m_valid[idx][w] && vic < 0) vic = w;
            if (vic < 0) begin
                vic = m_rr[idx];
                m_rr[idx] = (m_rr[idx] + 1) % NW;
            end
            if (m_valid[idx][vic] && m_dirty[idx][vic]) begin
                for (int b = 0; b < WPL; b++) begin
                    a = (m_tag[idx][vic] * NS + idx) * LINE_BYTES + b * 4;
                    exp_beat.push_back('{1'b1, a, m_data[idx][vic][b]});
                    mem_ref[a] = m_data[idx][vic][b];
                end
                m_wbs++;
            end
            for (int b = 0; b < WPL; b++) begin
                a = (tag * NS + idx) * LINE_BYTES + b * 4;
                exp_beat.push_back('{1'b0, a, '0});
                m_data[idx][vic][b] = ref_rd(a);
            end
            m_tag[idx][vic]   = tag;
            m_valid[idx][vic] = 1'b1;
            m_dirty[idx][vic] = wr;
            if (wr) m_data[idx][vic][word] = wdata;
            exp_resp.push_back('{m_data[idx][vic][word], 1'b0, acc});
        end
    endtask

    initial forever begin
        @(posedge clk);
        pcyc++;
    end

    // Memory responder and beat monitor.
    initial begin : mem_side
        int stall;
        bit prev_stall;
        logic [AW-1:0] prev_addr;
        logic [DW-1:0] prev_wdata;
        logic prev_wr;
        beat_t b;
        stall = 0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_ready = 1'b0;
                prev_stall = 1'b0;
                stall = 0;
            end else begin
                if (prev_stall) begin
                    check("mem_hold_valid", mem_valid, 1);
                    check("mem_hold_addr", mem_addr, prev_addr);
                    check("mem_hold_write", mem_write, prev_wr);
                    check("mem_hold_wdata", mem_wdata, prev_wdata);
                end
                case (ready_mode)
                    0: mem_ready = 1'b1;
                    1: mem_ready = 1'($urandom % 2);
                    default: begin
                        if (mem_valid && stall < 3) begin
                            mem_ready = 1'b0;
                            stall++;
                        end else begin
                            mem_ready = 1'b1;
                            stall = 0;
                        end
                    end
                endcase
                mem_rdata = dut_rd(mem_addr);
                if (mem_valid && mem_ready) begin
                    beats_done++;
                    check("beat_expected", exp_beat.size() > 0, 1);
                    if (exp_beat.size() > 0) begin
                        b = exp_beat.pop_front();
                        check("beat_write", mem_write, b.wr);
                        check("beat_addr", mem_addr, b.addr);
                        if (b.wr) check("beat_wdata", mem_wdata, b.wdata);
                    end
                    if (mem_write) mem_dut[mem_addr] = mem_wdata;
                end
                prev_stall = mem_valid && !mem_ready;
                prev_addr  = mem_addr;
                prev_wdata = mem_wdata;
                prev_wr    = mem_write;
            end
        end
    end

    // Response monitor.
    initial begin : resp_side
        resp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && resp_valid) begin
                check("resp_expected", exp_resp.size() > 0, 1);
                if (exp_resp.size() > 0) begin
                    e = exp_resp.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_hit", resp_hit, e.hit);
                    if (e.hit) check("hit_latency", pcyc - e.acc + 1, 2);
                end
            end else if (rst_n && exp_resp.size() > 0) begin
                check("req_ready_busy", req_ready, 0);
            end
        end
    end

    task automatic check_counters();
        check("hit_count", hit_count, sat(m_hits));
        check("miss_count", miss_count, sat(m_miss));
        check("wb_count", wb_count, sat(m_wbs));
    endtask

    task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        int t;
        t = 0;
        @(negedge clk); #1;
        while (!req_ready && t < 100) begin
            @(negedge clk); #1;
            t++;
        end
        check("req_ready_wait", req_ready, 1);
        if (req_ready) begin
            req_valid = 1'b1;
            req_write = wr;
            req_addr  = addr;
            req_wdata = wdata;
            model_access(wr, addr, wdata, pcyc + 1);
            @(posedge clk); #1;
            req_valid = 1'b0;
            req_wdata = $urandom;
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (exp_resp.size() > 0 && t < 3000) begin
            @(negedge clk); #1;
            req_valid = 1'b0;
            if (junk_en && exp_resp.size() > 0 && !req_ready && ($urandom % 3 == 0)) begin
                req_valid = 1'b1;
                req_write = 1'($urandom);
                req_addr  = $urandom & 32'h0000_0FFC;
            end
            t++;
        end
        req_valid = 1'b0;
        check("resp_timeout", exp_resp.size(), 0);
        if (exp_resp.size() > 0) begin
            exp_resp.delete();
            exp_beat.delete();
        end
        check_counters();
    endtask

    task automatic do_req(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        issue(wr, addr, wdata);
        wait_done();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bd0, t, mode;
        logic [AW-1:0] a;
        model_reset();
        #12;
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_counters", {hit_count, miss_count, wb_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_clk", req_ready, 0);
        @(posedge clk); #1;
        check("ready_after_clk", req_ready, 1);

        // Cold miss, hit, write hits, dirty evictions.
        ready_mode = 0;
        do_req(1'b0, 32'h140, '0);
        do_req(1'b0, 32'h148, '0);
        do_req(1'b1, 32'h144, 32'hDEADBEEF);
        do_req(1'b0, 32'h144, '0);
        do_req(1'b1, 32'h000, 32'h11);
        do_req(1'b1, 32'h080, 32'h22);
        do_req(1'b1, 32'h100, 32'h33);
        do_req(1'b1, 32'h180, 32'h44);
        do_req(1'b0, 32'h200, '0);
        do_req(1'b0, 32'h280, '0);

        // Back-pressure with stray requests while busy.
        ready_mode = 2;
        junk_en = 1'b1;
        do_req(1'b1, 32'h300, 32'hCAFE0001);
        do_req(1'b0, 32'h104, '0);
        junk_en = 1'b0;

        // Reset in the middle of a refill.
        ready_mode = 0;
        bd0 = beats_done;
        issue(1'b0, 32'h370, '0);
        t = 0;
        while (beats_done < bd0 + 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("refill_started", beats_done >= bd0 + 2, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_valid", mem_valid, 0);
        check("midrst_counters", {hit_count, miss_count, wb_count}, 0);
        check("midrst_resp_valid", resp_valid, 0);
        exp_resp.delete();
        exp_beat.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bd0 = beats_done;
        do_req(1'b0, 32'h370, '0);
        check("rerefill_beats", beats_done - bd0, WPL);

        // Randomized traffic over a small tag range.
        for (int i = 0; i < 200; i++) begin
            mode = $urandom % 3;
            ready_mode = mode;
            junk_en = 1'($urandom % 2);
            a = (($urandom % 5) * NS + ($urandom % NS)) * LINE_BYTES + ($urandom % WPL) * 4;
            do_req(1'($urandom % 2), a, $urandom);
        end
        junk_en = 1'b0;
        repeat (3) @(negedge clk);
        check("final_no_beats", exp_beat.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
